mult_operand_sequencer: RTL

MULT_OPERAND_SEQUENCER -- requirements
Module: mult_operand_sequencer

---
 rtl/mult_operand_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mult_operand_sequencer.sv
// Operand sequencer for a nibble-step multiplier: queues operand pairs in a
// 2-entry FIFO, launches one multiply at a time and captures the product.
module mult_operand_sequencer #(
    parameter int TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        reset_a,
    input  logic        in_valid,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic        in_ready,
    output logic        start,
    output logic [7:0]  dataa,
    output logic [7:0]  datab,
    output logic [1:0]  count,
    input  logic        done,
    input  logic [15:0] product,
    output logic [15:0] result,
    output logic        result_valid,
    output logic        err,
    input  logic        err_clr,
    output logic [1:0]  seq_state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_WAIT   = 2'd3;

    localparam int             WCW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    logic [1:0]     state;
    logic [1:0]     state_nxt;
    logic [15:0]    fifo_mem [2];
    logic           wr_ptr;
    logic           rd_ptr;
    logic [1:0]     occ;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic [WCW-1:0] wait_cnt;
    logic           wait_done;
    logic           wait_expire;

    // Handshake: an operand pair transfers on any rising edge where
    // in_valid && in_ready; in_ready depends only on FIFO occupancy.
    assign full     = (occ == 2'd2);
    assign empty    = (occ == 2'd0);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;

    assign wait_done   = (state == S_WAIT) && done;
    assign wait_expire = (state == S_WAIT) && !done && (wait_cnt == WAIT_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (!empty) state_nxt = S_LAUNCH;
            S_LAUNCH: state_nxt = S_RUN;
            S_RUN:    if (count == 2'd3) state_nxt = S_WAIT;
            S_WAIT: begin
                if (done)             state_nxt = empty ? S_IDLE : S_LAUNCH;
                else if (wait_expire) state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    // The FIFO head is consumed exactly on the edge that enters LAUNCH.
    assign pop       = (state_nxt == S_LAUNCH) && (state != S_LAUNCH);
    assign start     = (state == S_LAUNCH);
    assign seq_state = state;

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            occ         <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {in_a, in_b};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            dataa <= '0;
            datab <= '0;
            count <= 2'd0;
        end else begin
            if (pop) begin
                {dataa, datab} <= fifo_mem[rd_ptr];
                count          <= 2'd0;
            end else if ((state == S_RUN) && (state_nxt == S_RUN)) begin
                count <= count + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            wait_cnt <= '0;
        end else if ((state != S_WAIT) && (state_nxt == S_WAIT)) begin
            wait_cnt <= '0;
        end else if ((state == S_WAIT) && !done && !wait_expire) begin
            wait_cnt <= wait_cnt + WCW'(1);
        end
    end

    // A set source (stray done or WAIT timeout) overrides err_clr.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            result       <= '0;
            result_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            result_valid <= wait_done;
            if (wait_done) begin
                result <= product;
            end
            if ((done && (state != S_WAIT)) || wait_expire) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule
